ic_fill_ctrl: RTL and testbench
===============================

Name: ic_fill_ctrl

Overview:
Lookup and refill controller for the direct-mapped 1-way waveform cache; sits directly upstream of the cache data RAM and drives its write port (line refills) and read address.
- Holds the tag/valid array in registers.
- Accepts one sample-word read request at a time.
- On a miss, bursts the full line from external memory into the data RAM, then returns the requested word.

Parameters:
RAM_DW, 128, data RAM word width (bits); equals the memory read data width
RAM_AW, 9, data RAM address width (512 words)
LINE_LOG2, 2, log2 words per line (4 words/line; 128 lines)
ADDR_W, 24, request word-address width; TAG_W = ADDR_W - RAM_AW

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  read request valid
req_ready  out  1  controller can accept request
req_addr  in  ADDR_W  word address
rsp_valid  out  1  response data valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  RAM_DW  returned word
rsp_hit  out  1  response was a cache hit
flush  in  1  one-cycle pulse, invalidate all lines
mem_arvalid  out  1  burst read request
mem_arready  in  1  memory accepts request
mem_araddr  out  ADDR_W  line-aligned word address
mem_arlen  out  8  beats minus 1 (constant 2^LINE_LOG2-1)
mem_rvalid  in  1  read beat valid
mem_rready  out  1  controller accepts beat
mem_rdata  in  RAM_DW  read beat data
mem_rlast  in  1  last beat marker
ram_wea  out  1  data RAM write enable
ram_addra  out  RAM_AW  data RAM write address
ram_dina  out  RAM_DW  data RAM write data
ram_addrb  out  RAM_AW  data RAM read address (asynchronous read)
ram_doutb  in  RAM_DW  data RAM read data
fill_err  out  1  sticky: mem_rlast disagreed with beat count

Behaviour:
- Address split: offset = addr[LINE_LOG2-1:0]; index = addr[RAM_AW-1:LINE_LOG2]; tag = addr[ADDR_W-1:RAM_AW].
- Reset: state IDLE. All valid bits, req_ready, rsp_valid, rsp_hit, mem_arvalid, mem_rready, ram_wea and fill_err are 0; rsp_data is 0. The tag array is not reset.
- States: IDLE, LOOKUP, MISS_REQ, FILL, RESP.
- IDLE: req_ready=1. When req_valid is high, latch req_addr and go to LOOKUP.
- LOOKUP: ram_addrb = {index, offset}. The line hits if valid[index] is set and tag[index] equals the latched tag.
  - Hit: register ram_doutb into rsp_data, set rsp_hit=1, go to RESP.
  - Miss: set rsp_hit=0, go to MISS_REQ.
- Hit latency: request accepted at edge N; rsp_valid=1 from edge N+2.
- MISS_REQ: mem_arvalid=1, mem_araddr = {tag, index, LINE_LOG2 zero bits}. Both are held stable until mem_arready; on that edge clear beat_cnt and go to FILL.
- FILL: mem_rready=1. Each beat with mem_rvalid high:
  - Drives ram_wea=1, ram_addra = {index, beat_cnt}, ram_dina = mem_rdata combinationally in the same cycle.
  - If beat_cnt equals offset, captures mem_rdata into rsp_data.
  - Increments beat_cnt.
- Fill end: the beat with beat_cnt = 2^LINE_LOG2-1 is last. On it, write tag[index] and set valid[index], then go to RESP.
  - Termination is count-based only.
  - fill_err is set (sticky until rst) when mem_rlast does not equal (beat is last).
- RESP: rsp_valid=1. rsp_data and rsp_hit are held until rsp_ready. When rsp_valid & rsp_ready, go to IDLE; the next request can be accepted one cycle later.
- flush: clears every valid bit on the edge where it is sampled, in any state.
  - If flush coincides with the final fill beat, flush wins: the line stays invalid, but the response still returns the fetched word.
  - A flush during LOOKUP takes effect on the next lookup only; the current cycle's comparison uses the pre-flush valid bits.
- ram_addrb outside LOOKUP is don't-care. Drive {latched index, offset} to avoid toggling.
- rst in any state, including mid-fill, returns to IDLE immediately and drops mem_arvalid/mem_rready. The memory side must be reset alongside; partially written RAM words are harmless because valid stays 0.

Test Plan:
- Cold miss: rst, then req 0x000005. Required: mem_araddr=0x000004, arlen=3; four beats D0..D3 written to RAM addresses 4..7; rsp_data=D1, rsp_hit=0.
- Hit after fill: req 0x000007. Required: no mem_arvalid, rsp_valid 2 cycles after acceptance, rsp_data=D3, rsp_hit=1.
- Conflict miss: req 0x000205 (same index, tag 1). Required: refill from 0x000204 into RAM 4..7; a following req 0x000005 misses again.
- Backpressure: hold mem_arready=0 for 5 cycles, insert mem_rvalid gaps, hold rsp_ready=0 for 3 cycles. Required: araddr stable, no extra RAM writes, rsp_data unchanged until accepted.
- Flush on last beat: pulse flush with beat 3. Required: correct rsp_data, then the same address misses again.
- Errors/reset: mem_rlast on beat 1 sets fill_err, and the fill still takes 4 beats. rst asserted after beat 2 returns to IDLE with req_ready=1 next cycle, and the address then misses.

Source files
------------

// File: rtl/ic_fill_ctrl.sv
// Direct-mapped waveform cache lookup/refill: tag/valid in flops, one request in flight.
// Hit: rsp_valid two edges after accept; miss bursts a line first; stalls on mem_arready/mem_rvalid/rsp_ready.
module ic_fill_ctrl #(
    parameter int RAM_DW    = 128,
    parameter int RAM_AW    = 9,
    parameter int LINE_LOG2 = 2,
    parameter int ADDR_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RAM_DW-1:0] rsp_data,
    output logic              rsp_hit,
    input  logic              flush,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [7:0]        mem_arlen,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [RAM_DW-1:0] mem_rdata,
    input  logic              mem_rlast,
    output logic              ram_wea,
    output logic [RAM_AW-1:0] ram_addra,
    output logic [RAM_DW-1:0] ram_dina,
    output logic [RAM_AW-1:0] ram_addrb,
    input  logic [RAM_DW-1:0] ram_doutb,
    output logic              fill_err
);
    localparam int TAG_W  = ADDR_W - RAM_AW;
    localparam int IDX_W  = RAM_AW - LINE_LOG2;
    localparam int NLINES = 1 << IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, FILL, RESP} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LINE_LOG2-1:0] beat_q, beat_d;
    logic [NLINES-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [NLINES];
    logic [RAM_DW-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic                 fill_err_q, fill_err_d;
    logic                 tag_we;

    logic [LINE_LOG2-1:0] offset;
    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     tag;
    logic                 hit;
    logic                 beat_last;

    assign offset    = addr_q[LINE_LOG2-1:0];
    assign index     = addr_q[RAM_AW-1:LINE_LOG2];
    assign tag       = addr_q[ADDR_W-1:RAM_AW];
    assign hit       = valid_q[index] && (tag_q[index] == tag);
    assign beat_last = (beat_q == {LINE_LOG2{1'b1}});

    // Handshake outputs are gated by rst so the memory side sees them drop at once.
    assign req_ready   = (state_q == IDLE)     && !rst;
    assign rsp_valid   = (state_q == RESP)     && !rst;
    assign mem_arvalid = (state_q == MISS_REQ) && !rst;
    assign mem_rready  = (state_q == FILL)     && !rst;
    assign ram_wea     = (state_q == FILL)     && !rst && mem_rvalid;
    assign mem_araddr  = {addr_q[ADDR_W-1:LINE_LOG2], {LINE_LOG2{1'b0}}};
    assign mem_arlen   = 8'((1 << LINE_LOG2) - 1);
    assign ram_addra   = {index, beat_q};
    assign ram_dina    = mem_rdata;
    assign ram_addrb   = {index, offset};
    assign rsp_data    = rsp_data_q;
    assign rsp_hit     = rsp_hit_q;
    assign fill_err    = fill_err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        rsp_data_d = rsp_data_q;
        rsp_hit_d  = rsp_hit_q;
        fill_err_d = fill_err_q;
        tag_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    rsp_data_d = ram_doutb;
                    rsp_hit_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    rsp_hit_d  = 1'b0;
                    state_d    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_arready) begin
                    beat_d  = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rvalid) begin
                    if (beat_q == offset) rsp_data_d = mem_rdata;
                    beat_d = beat_q + 1'b1;
                    // The burst ends on beat count; rlast is only cross-checked.
                    if (mem_rlast != beat_last) fill_err_d = 1'b1;
                    if (beat_last) begin
                        tag_we         = 1'b1;
                        valid_d[index] = 1'b1;
                        state_d        = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A coincident flush overrides the valid set of a completing fill.
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            valid_q    <= '0;
            rsp_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            fill_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            valid_q    <= valid_d;
            rsp_data_q <= rsp_data_d;
            rsp_hit_q  <= rsp_hit_d;
            fill_err_q <= fill_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we && !rst) tag_q[index] <= tag;
    end
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed bench for ic_fill_ctrl: memory/RAM models plus a response scoreboard.
module tb_ic_fill_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [23:0]  req_addr;
    logic         rsp_valid, rsp_ready, rsp_hit;
    logic [127:0] rsp_data;
    logic         flush;
    logic         mem_arvalid, mem_arready;
    logic [23:0]  mem_araddr;
    logic [7:0]   mem_arlen;
    logic         mem_rvalid, mem_rready, mem_rlast;
    logic [127:0] mem_rdata;
    logic         ram_wea;
    logic [8:0]   ram_addra, ram_addrb;
    logic [127:0] ram_dina, ram_doutb;
    logic         fill_err;

    logic [127:0] tb_ram [512];
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    typedef struct {
        logic [127:0] d;
        logic         h;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ic_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
        .flush(flush),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .fill_err(fill_err)
    );

    assign ram_doutb = tb_ram[ram_addrb];

    always @(posedge clk) if (ram_wea) tb_ram[ram_addra] <= ram_dina;
    always @(negedge clk) if (ram_wea) wr_cnt++;

    function automatic logic [127:0] mkdat(input logic [23:0] a, input logic [31:0] salt);
        return {salt, 8'h00, a, salt, 8'h00, a};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshake is stable from the negedge to the next posedge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_hit", {127'b0, rsp_hit}, {127'b0, e.h});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [23:0] a, input logic [127:0] d, input logic h);
        int n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        chk("req_ready_wait", {127'b0, req_ready}, 128'd1);
        req_valid = 1'b1;
        req_addr  = a;
        e.d = d;
        e.h = h;
        exp_q.push_back(e);
        tick();
        req_valid = 1'b0;
        if (h) begin
            chk("hit_lookup_cycle", {127'b0, rsp_valid}, 128'd0);
            tick();
            chk("hit_latency", {127'b0, rsp_valid}, 128'd1);
            chk("hit_no_arvalid", {127'b0, mem_arvalid}, 128'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
        chk("rsp_drained", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic serve_fill(input logic [23:0] line, input logic [31:0] salt, input int ar_delay,
                              input logic [3:0] gaps, input int bad_last, input int flush_beat,
                              input int nbeats);
        int n, w0;
        logic [8:0] wa;
        n = 0;
        while (!mem_arvalid && n < 50) begin tick(); n++; end
        chk("arvalid_seen", {127'b0, mem_arvalid}, 128'd1);
        chk("araddr", 128'(mem_araddr), 128'(line));
        chk("arlen", 128'(mem_arlen), 128'd3);
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            chk("araddr_stable", {103'b0, mem_arvalid, mem_araddr}, {103'b0, 1'b1, line});
        end
        mem_arready = 1'b1;
        tick();
        mem_arready = 1'b0;
        chk("arvalid_drop", {127'b0, mem_arvalid}, 128'd0);
        w0 = wr_cnt;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps[b]) tick();
            wa = line[8:0] + 9'(b);
            mem_rvalid = 1'b1;
            mem_rdata  = mkdat(line + 24'(b), salt);
            mem_rlast  = (b == 3) || (b == bad_last);
            flush      = (b == flush_beat);
            @(negedge clk);
            chk("beat_wr", {118'b0, mem_rready, ram_wea, wa}, {118'b0, 1'b1, 1'b1, ram_addra});
            chk("beat_addr", 128'(ram_addra), 128'(wa));
            chk("beat_din", ram_dina, mkdat(line + 24'(b), salt));
            tick();
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            flush      = 1'b0;
        end
        if (nbeats == 4) chk("fill_write_count", 128'(wr_cnt - w0), 128'd4);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 512; i++) tb_ram[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        tick(); tick();
        chk("rst_outputs", {120'b0, req_ready, rsp_valid, rsp_hit, mem_arvalid, mem_rready,
                            ram_wea, fill_err, 1'b0}, 128'd0);
        chk("rst_rsp_data", rsp_data, 128'd0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", {127'b0, req_ready}, 128'd1);

        // Cold miss, then hit on the same line.
        issue_req(24'h000005, mkdat(24'h000005, 32'h1111_0001), 1'b0);
        serve_fill(24'h000004, 32'h1111_0001, 0, 4'b0000, -1, -1, 4);
        drain();
        issue_req(24'h000007, mkdat(24'h000007, 32'h1111_0001), 1'b1);
        drain();

        // Conflict miss on the same index, then the original address misses again.
        issue_req(24'h000205, mkdat(24'h000205, 32'h2222_0002), 1'b0);
        serve_fill(24'h000204, 32'h2222_0002, 0, 4'b0000, -1, -1, 4);
        drain();
        issue_req(24'h000005, mkdat(24'h000005, 32'h3333_0003), 1'b0);
        serve_fill(24'h000004, 32'h3333_0003, 0, 4'b0000, -1, -1, 4);
        drain();

        // Backpressure on all three interfaces.
        rsp_ready = 1'b0;
        issue_req(24'h000013, mkdat(24'h000013, 32'h4444_0004), 1'b0);
        serve_fill(24'h000010, 32'h4444_0004, 5, 4'b1010, -1, -1, 4);
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", {127'b0, rsp_valid}, 128'd1);
            chk("bp_rsp_data", rsp_data, mkdat(24'h000013, 32'h4444_0004));
            tick();
        end
        rsp_ready = 1'b1;
        drain();
        issue_req(24'h000010, mkdat(24'h000010, 32'h4444_0004), 1'b1);
        drain();

        // Flush coincident with the last beat; flush also dropped every other line.
        issue_req(24'h000022, mkdat(24'h000022, 32'h5555_0005), 1'b0);
        serve_fill(24'h000020, 32'h5555_0005, 0, 4'b0000, -1, 3, 4);
        drain();
        issue_req(24'h000022, mkdat(24'h000022, 32'h6666_0006), 1'b0);
        serve_fill(24'h000020, 32'h6666_0006, 0, 4'b0000, -1, -1, 4);
        drain();
        issue_req(24'h000005, mkdat(24'h000005, 32'h7777_0007), 1'b0);
        serve_fill(24'h000004, 32'h7777_0007, 0, 4'b0000, -1, -1, 4);
        drain();

        // Early rlast flags an error but the line still fills by count.
        chk("fill_err_clear", {127'b0, fill_err}, 128'd0);
        issue_req(24'h000031, mkdat(24'h000031, 32'h8888_0008), 1'b0);
        serve_fill(24'h000030, 32'h8888_0008, 0, 4'b0000, 1, -1, 4);
        drain();
        chk("fill_err_set", {127'b0, fill_err}, 128'd1);
        issue_req(24'h000033, mkdat(24'h000033, 32'h8888_0008), 1'b1);
        drain();
        chk("fill_err_sticky", {127'b0, fill_err}, 128'd1);

        // Reset after beat 2 abandons the fill; the line must miss afterwards.
        issue_req(24'h000102, mkdat(24'h000102, 32'h9999_0009), 1'b0);
        serve_fill(24'h000100, 32'h9999_0009, 0, 4'b0000, -1, -1, 3);
        rst = 1'b1;
        #1;
        chk("rst_drops_rready", {126'b0, mem_rready, mem_arvalid}, 128'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {126'b0, req_ready, fill_err}, 128'd2);
        issue_req(24'h000102, mkdat(24'h000102, 32'hAAAA_000A), 1'b0);
        serve_fill(24'h000100, 32'hAAAA_000A, 0, 4'b0000, -1, -1, 4);
        drain();

        n = 0;
        while (n < 3) begin tick(); n++; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
